forward_local_bpms: RTL and testbench

Store-and-forward buffer between the local-BPM merger and the cell-link transmitter, all in the Aurora user clock domain. It accepts the 4-word-per-BPM record stream (header, X error, Y error, sum), which arrives with no back-pressure, and checks its framing. It buffers only complete, well-formed packets and replays them as an AXI stream that honours TREADY. It also latches per-session counts for the IOC.

---
 rtl/forward_local_bpms_pkg.sv | 28 ++
 rtl/forward_local_bpms_ram.sv | 47 ++++
 rtl/forward_local_bpms.sv | 227 ++++++++++++++++++++++
 tb/tb_forward_local_bpms.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/forward_local_bpms_pkg.sv
// forward_local_bpms_pkg: shared types and constants for the local-BPM
// store-and-forward buffer.
//   in_state_e           - input framing FSM states
//   HEADER_MAGIC_DEFAULT - expected header word bits [31:16]
//   WORDS_PER_RECORD     - header, X error, Y error, sum
//   sat_inc6/sat_inc8    - saturating counter increments
package forward_local_bpms_pkg;

  typedef enum logic [2:0] {
    EXP_HDR = 3'd0,
    EXP_X   = 3'd1,
    EXP_Y   = 3'd2,
    EXP_S   = 3'd3,
    DISCARD = 3'd4
  } in_state_e;

  localparam logic [15:0] HEADER_MAGIC_DEFAULT = 16'hA5BE;
  localparam int unsigned WORDS_PER_RECORD     = 32'd4;

  function automatic logic [5:0] sat_inc6(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'd255) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/forward_local_bpms_ram.sv
// forward_local_bpms_ram: simple dual-port RAM, one write port and one
// registered read port. The read register only updates when re_i is high,
// so it doubles as the stream output register and holds during stalls.
//   clk_i    - clock
//   rst_n_i  - synchronous active-low reset (clears the read register only)
//   we_i, waddr_i, wdata_i - write port
//   re_i, raddr_i          - read request
//   rdata_o  - registered read data
module forward_local_bpms_ram
  import forward_local_bpms_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32'd8,
  parameter int unsigned DATA_WIDTH = 32'd33
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared by reset so the stream outputs start at zero.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/forward_local_bpms.sv
// forward_local_bpms: store-and-forward buffer between the local-BPM merger
// and the cell-link transmitter (single Aurora user clock domain).
// Accepts 4-word records (header, X, Y, sum) with no back-pressure, checks
// framing, commits only complete well-formed records and replays committed
// packets as an AXI stream honouring cellTx_tready.
//   auroraUserClk/auroraUserResetN - clock, synchronous active-low reset
//   auroraFAstrobe                 - session start: abort-close, latch counts
//   localBPMs_*                    - input record stream (no ready)
//   cellTx_*                       - output stream
//   sessionRecordCount/ErrorCount  - counts of the previous session
//   overflowFlag                   - sticky overflow indicator
// Build option: FORWARD_LOCAL_BPMS_HEADER_CHECK_EN enables the header magic check.
module forward_local_bpms
  import forward_local_bpms_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32'd8,
  parameter logic [15:0] HEADER_MAGIC = HEADER_MAGIC_DEFAULT
) (
  input  logic        auroraUserClk,
  input  logic        auroraUserResetN,
  input  logic        auroraFAstrobe,
  input  logic [31:0] localBPMs_tdata,
  input  logic        localBPMs_tvalid,
  input  logic        localBPMs_tlast,
  output logic [31:0] cellTx_tdata,
  output logic        cellTx_tvalid,
  output logic        cellTx_tlast,
  input  logic        cellTx_tready,
  output logic [5:0]  sessionRecordCount,
  output logic [7:0]  sessionErrorCount,
  output logic        overflowFlag
);
  localparam int unsigned     PW            = ADDR_WIDTH + 32'd1;
  localparam logic [PW-1:0]   PTR_ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]      LAST_WORD_IDX = 3'(WORDS_PER_RECORD - 32'd1);

  in_state_e       state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rec_start_q, rec_start_d;
  logic [PW-1:0]   last_good_s_q, last_good_s_d;
  logic [31:0]     last_good_data_q, last_good_data_d;
  logic            has_good_q, has_good_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [5:0]      rec_cnt_q, rec_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [5:0]      sess_rec_q, sess_rec_d;
  logic [7:0]      sess_err_q, sess_err_d;
  logic            overflow_q, overflow_d;

  logic                  we_s;
  logic [ADDR_WIDTH-1:0] waddr_s;
  logic [32:0]           wdata_s;
  logic                  rd_en_s;
  logic [32:0]           ram_rdata_s;
  logic [PW-1:0]         occ_s;
  logic                  full_s;
  logic                  consume_s;
  logic                  is_last_word_s;
  logic                  frame_err_s;
  logic                  hdr_bad_s;

`ifdef FORWARD_LOCAL_BPMS_HEADER_CHECK_EN
  assign hdr_bad_s = (localBPMs_tdata[31:16] != HEADER_MAGIC);
`else
  logic unused_hdr_magic_s;
  assign unused_hdr_magic_s = ^HEADER_MAGIC;
  assign hdr_bad_s          = 1'b0;
`endif

  // Occupancy counts words not yet moved into the output register.
  assign occ_s          = wr_ptr_q - rd_ptr_q;
  assign full_s         = occ_s[ADDR_WIDTH];
  assign consume_s      = localBPMs_tvalid && !auroraFAstrobe;
  assign is_last_word_s = (state_q == in_state_e'(LAST_WORD_IDX));
  assign frame_err_s    = ((state_q == EXP_HDR) && hdr_bad_s) ||
                          (localBPMs_tlast && !is_last_word_s);

  // Input framing FSM, write pointer management, commit and counters.
  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rec_start_d      = rec_start_q;
    last_good_s_d    = last_good_s_q;
    last_good_data_d = last_good_data_q;
    has_good_d       = has_good_q;
    commit_ptr_d     = commit_ptr_q;
    rec_cnt_d        = rec_cnt_q;
    err_cnt_d        = err_cnt_q;
    sess_rec_d       = sess_rec_q;
    sess_err_d       = sess_err_q;
    overflow_d       = overflow_q;
    we_s             = 1'b0;
    waddr_s          = wr_ptr_q[ADDR_WIDTH-1:0];
    wdata_s          = {localBPMs_tlast, localBPMs_tdata};

    if (auroraFAstrobe || (consume_s && (state_q != DISCARD) && (full_s || frame_err_s))) begin
      // Abort: the current partial record is dropped. If the packet already
      // holds good records, re-write the last good S word with its last bit
      // set and commit through it. The write port is free this cycle because
      // the incoming word is not stored.
      if (has_good_q) begin
        we_s         = 1'b1;
        waddr_s      = last_good_s_q[ADDR_WIDTH-1:0];
        wdata_s      = {1'b1, last_good_data_q};
        commit_ptr_d = last_good_s_q + PTR_ONE;
      end else begin
        commit_ptr_d = commit_ptr_q;
      end
      wr_ptr_d   = rec_start_q;
      has_good_d = 1'b0;
      if (auroraFAstrobe) begin
        state_d    = EXP_HDR;
        sess_rec_d = rec_cnt_q;
        sess_err_d = err_cnt_q;
        rec_cnt_d  = 6'd0;
        err_cnt_d  = 8'd0;
      end else begin
        err_cnt_d  = sat_inc8(err_cnt_q);
        overflow_d = overflow_q | full_s;
        state_d    = localBPMs_tlast ? EXP_HDR : DISCARD;
      end
    end else if (!consume_s) begin
      state_d = state_q;
    end else if (state_q == DISCARD) begin
      state_d = localBPMs_tlast ? EXP_HDR : DISCARD;
    end else begin
      we_s     = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      case (state_q)
        EXP_HDR: state_d = EXP_X;
        EXP_X:   state_d = EXP_Y;
        EXP_Y:   state_d = EXP_S;
        EXP_S:   state_d = EXP_HDR;
        default: state_d = EXP_HDR;
      endcase
      if (is_last_word_s) begin
        rec_cnt_d        = sat_inc6(rec_cnt_q);
        rec_start_d      = wr_ptr_q + PTR_ONE;
        last_good_s_d    = wr_ptr_q;
        last_good_data_d = localBPMs_tdata;
        if (localBPMs_tlast) begin
          commit_ptr_d = wr_ptr_q + PTR_ONE;
          has_good_d   = 1'b0;
        end else begin
          has_good_d   = 1'b1;
        end
      end else begin
        rec_start_d = rec_start_q;
      end
    end
  end

  // Output side: pull the next committed word whenever the output register
  // is empty or being drained this cycle.
  always_comb begin
    rd_en_s = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || cellTx_tready);
    if (rd_en_s) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b1;
    end else if (cellTx_tready) begin
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = 1'b0;
    end else begin
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge auroraUserClk) begin
    if (!auroraUserResetN) begin
      state_q          <= EXP_HDR;
      wr_ptr_q         <= '0;
      rec_start_q      <= '0;
      last_good_s_q    <= '0;
      last_good_data_q <= 32'd0;
      has_good_q       <= 1'b0;
      commit_ptr_q     <= '0;
      rd_ptr_q         <= '0;
      out_valid_q      <= 1'b0;
      rec_cnt_q        <= 6'd0;
      err_cnt_q        <= 8'd0;
      sess_rec_q       <= 6'd0;
      sess_err_q       <= 8'd0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rec_start_q      <= rec_start_d;
      last_good_s_q    <= last_good_s_d;
      last_good_data_q <= last_good_data_d;
      has_good_q       <= has_good_d;
      commit_ptr_q     <= commit_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      out_valid_q      <= out_valid_d;
      rec_cnt_q        <= rec_cnt_d;
      err_cnt_q        <= err_cnt_d;
      sess_rec_q       <= sess_rec_d;
      sess_err_q       <= sess_err_d;
      overflow_q       <= overflow_d;
    end
  end

  forward_local_bpms_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (32'd33)
  ) u_ram (
    .clk_i   (auroraUserClk),
    .rst_n_i (auroraUserResetN),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .re_i    (rd_en_s),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata_s)
  );

  assign cellTx_tdata       = ram_rdata_s[31:0];
  assign cellTx_tlast       = ram_rdata_s[32];
  assign cellTx_tvalid      = out_valid_q;
  assign sessionRecordCount = sess_rec_q;
  assign sessionErrorCount  = sess_err_q;
  assign overflowFlag       = overflow_q;

endmodule

// File: tb/tb_forward_local_bpms.sv
module tb_forward_local_bpms;
  logic        clk;
  logic        rst_n;
  logic        strobe;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;
  logic [5:0]  rec_cnt;
  logic [7:0]  err_cnt;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_in_cyc = 0;
  logic [32:0] got_q [$];
  int          got_cyc_q [$];
  logic [32:0] exp_q [$];

  forward_local_bpms dut (
    .auroraUserClk      (clk),
    .auroraUserResetN   (rst_n),
    .auroraFAstrobe     (strobe),
    .localBPMs_tdata    (in_data),
    .localBPMs_tvalid   (in_valid),
    .localBPMs_tlast    (in_last),
    .cellTx_tdata       (tx_data),
    .cellTx_tvalid      (tx_valid),
    .cellTx_tlast       (tx_last),
    .cellTx_tready      (tx_ready),
    .sessionRecordCount (rec_cnt),
    .sessionErrorCount  (err_cnt),
    .overflowFlag       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture handshakes mid-cycle; values there equal those at the next edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) begin
      got_q.push_back({tx_last, tx_data});
      got_cyc_q.push_back(cyc);
    end
    if (in_valid && in_last && !strobe) last_in_cyc = cyc;
  end

  function automatic logic [31:0] rec_word(input logic [31:0] hdr, input int i);
    case (i)
      1:       return {8'h11, hdr[23:0]};
      2:       return {8'h22, hdr[23:0]};
      3:       return {8'h33, hdr[23:0]};
      default: return hdr;
    endcase
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l);
    @(posedge clk); #1;
    in_data = d; in_valid = 1'b1; in_last = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_data = 32'd0; in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic send_record(input logic [31:0] hdr, input logic l);
    for (int i = 0; i < 4; i++) send_word(rec_word(hdr, i), (i == 3) ? l : 1'b0);
  endtask

  task automatic push_rec(input logic [31:0] hdr, input logic l);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? l : 1'b0, rec_word(hdr, i)});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; strobe = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 32'd0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic strobe_pulse();
    @(posedge clk); #1;
    strobe = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (got_q.size() >= n) break;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tx_valid); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tx_last); end
    checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_tdata got %h want 0", tx_data); end
    checks++; if (rec_cnt !== 6'd0) begin errors++; $display("FAIL reset_rec got %0d want 0", rec_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
  endtask

  task automatic test_two_records();
    int base;
    logic [32:0] obs;
    do_reset();
    base = got_q.size(); exp_q.delete();
    send_record(32'hA5BE0003, 1'b0);
    send_record(32'hA5BE0007, 1'b1);
    idle(1);
    push_rec(32'hA5BE0003, 1'b0);
    push_rec(32'hA5BE0007, 1'b1);
    wait_words(base + 8, 40);
    idle(5);
    checks++; if (got_q.size() - base !== 8) begin errors++; $display("FAIL two_count got %0d want 8", got_q.size() - base); end
    for (int i = 0; i < 8; i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 33'bx;
      checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL two_word%0d got %h want %h", i, obs, exp_q[i]); end
    end
    if (got_q.size() > base) begin
      checks++;
      if (got_cyc_q[base] - last_in_cyc !== 2) begin
        errors++; $display("FAIL two_latency got %0d want 2", got_cyc_q[base] - last_in_cyc);
      end
    end
    checks++; if (rec_cnt !== 6'd0) begin errors++; $display("FAIL two_rec_prelatch got %0d want 0", rec_cnt); end
    strobe_pulse();
    checks++; if (rec_cnt !== 6'd2) begin errors++; $display("FAIL two_rec got %0d want 2", rec_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL two_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_bad_header();
    int base;
    int n_exp;
    logic [32:0] obs;
    logic [5:0] rec_exp;
    logic [7:0] err_exp;
    do_reset();
    base = got_q.size(); exp_q.delete();
    send_record(32'hA5BE0003, 1'b0);
    send_record(32'h12340005, 1'b1);
    idle(1);
`ifdef FORWARD_LOCAL_BPMS_HEADER_CHECK_EN
    push_rec(32'hA5BE0003, 1'b1);
    rec_exp = 6'd1; err_exp = 8'd1;
`else
    push_rec(32'hA5BE0003, 1'b0);
    push_rec(32'h12340005, 1'b1);
    rec_exp = 6'd2; err_exp = 8'd0;
`endif
    n_exp = exp_q.size();
    wait_words(base + n_exp, 40);
    idle(5);
    checks++; if (got_q.size() - base !== n_exp) begin errors++; $display("FAIL badhdr_count got %0d want %0d", got_q.size() - base, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 33'bx;
      checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL badhdr_word%0d got %h want %h", i, obs, exp_q[i]); end
    end
    strobe_pulse();
    checks++; if (rec_cnt !== rec_exp) begin errors++; $display("FAIL badhdr_rec got %0d want %0d", rec_cnt, rec_exp); end
    checks++; if (err_cnt !== err_exp) begin errors++; $display("FAIL badhdr_err got %0d want %0d", err_cnt, err_exp); end
  endtask

  task automatic test_tlast_on_x();
    int base;
    logic [32:0] obs;
    do_reset();
    base = got_q.size(); exp_q.delete();
    send_record(32'hA5BE0001, 1'b0);
    send_word(32'hA5BE0002, 1'b0);
    send_word(rec_word(32'hA5BE0002, 1), 1'b1);
    idle(1);
    push_rec(32'hA5BE0001, 1'b1);
    wait_words(base + 4, 40);
    idle(5);
    checks++; if (got_q.size() - base !== 4) begin errors++; $display("FAIL xlast_count got %0d want 4", got_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 33'bx;
      checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL xlast_word%0d got %h want %h", i, obs, exp_q[i]); end
    end
    strobe_pulse();
    checks++; if (rec_cnt !== 6'd1) begin errors++; $display("FAIL xlast_rec got %0d want 1", rec_cnt); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL xlast_err got %0d want 1", err_cnt); end
  endtask

  task automatic test_overflow();
    int base;
    logic [32:0] obs;
    logic [31:0] hdr;
    do_reset();
    base = got_q.size(); exp_q.delete();
    tx_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 32; r++) begin
        hdr = {16'hA5BE, 8'(p), 8'(r)};
        send_record(hdr, (r == 31));
        if (p < 2) push_rec(hdr, (r == 31));
      end
    end
    idle(3);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
    checks++; if (got_q.size() !== base) begin errors++; $display("FAIL ovf_stalled got %0d want 0", got_q.size() - base); end
    checks++; if ({tx_valid, tx_last, tx_data} !== {1'b1, exp_q[0]}) begin
      errors++; $display("FAIL ovf_hold got %b %h want 1 %h", tx_valid, {tx_last, tx_data}, exp_q[0]);
    end
    tx_ready = 1'b1;
    wait_words(base + 256, 400);
    idle(10);
    checks++; if (got_q.size() - base !== 256) begin errors++; $display("FAIL ovf_count got %0d want 256", got_q.size() - base); end
    for (int i = 0; i < 256; i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 33'bx;
      checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL ovf_word%0d got %h want %h", i, obs, exp_q[i]); end
    end
    if (got_q.size() >= base + 256) begin
      checks++;
      if (got_cyc_q[base + 255] - got_cyc_q[base] !== 255) begin
        errors++; $display("FAIL ovf_rate got %0d want 255", got_cyc_q[base + 255] - got_cyc_q[base]);
      end
    end
    strobe_pulse();
    checks++; if (rec_cnt !== 6'd63) begin errors++; $display("FAIL ovf_rec_sat got %0d want 63", rec_cnt); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ovf_err got %0d want 1", err_cnt); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_strobe_mid();
    int base;
    logic [32:0] obs;
    do_reset();
    base = got_q.size(); exp_q.delete();
    send_record(32'hA5BE0001, 1'b0);
    send_record(32'hA5BE0002, 1'b0);
    send_word(32'hA5BE0003, 1'b0);
    send_word(rec_word(32'hA5BE0003, 1), 1'b0);
    @(posedge clk); #1;
    in_data = rec_word(32'hA5BE0003, 2); in_valid = 1'b1; in_last = 1'b0; strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; in_valid = 1'b0;
    checks++; if (rec_cnt !== 6'd2) begin errors++; $display("FAIL strb_rec got %0d want 2", rec_cnt); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL strb_err got %0d want 0", err_cnt); end
    push_rec(32'hA5BE0001, 1'b0);
    push_rec(32'hA5BE0002, 1'b1);
    send_record(32'hA5BE0009, 1'b1);
    idle(1);
    push_rec(32'hA5BE0009, 1'b1);
    wait_words(base + 12, 40);
    idle(5);
    checks++; if (got_q.size() - base !== 12) begin errors++; $display("FAIL strb_count got %0d want 12", got_q.size() - base); end
    for (int i = 0; i < 12; i++) begin
      obs = (base + i < got_q.size()) ? got_q[base + i] : 33'bx;
      checks++; if (obs !== exp_q[i]) begin errors++; $display("FAIL strb_word%0d got %h want %h", i, obs, exp_q[i]); end
    end
    strobe_pulse();
    checks++; if (rec_cnt !== 6'd1) begin errors++; $display("FAIL strb_rec2 got %0d want 1", rec_cnt); end
  endtask

  task automatic test_reset_mid_output();
    int base;
    int snap;
    logic seen;
    do_reset();
    base = got_q.size();
    send_record(32'hA5BE0001, 1'b0);
    send_record(32'hA5BE0002, 1'b1);
    idle(1);
    wait_words(base + 3, 40);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 32'd0) begin errors++; $display("FAIL rstmid_tdata got %h want 0", tx_data); end
    snap = got_q.size();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (tx_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_empty got %b want 0", seen); end
    checks++; if (got_q.size() !== snap) begin errors++; $display("FAIL rstmid_words got %0d want 0", got_q.size() - snap); end
  endtask

  initial begin
    rst_n = 1'b0; strobe = 1'b0; in_data = 32'd0; in_valid = 1'b0;
    in_last = 1'b0; tx_ready = 1'b1;
    test_reset();
    test_two_records();
    test_bad_header();
    test_tlast_on_x();
    test_overflow();
    test_strobe_mid();
    test_reset_mid_output();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
